// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and helpers for the serial chunk adder.
//   state_t : FSM state encoding (IDLE, BUSY, DONE)
//   nchunk  : number of CHUNK-bit slices in a WIDTH-bit operand
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
//   master : operand producer / result consumer side
//   slave  : adder side
//   in_valid/in_ready  : operand handshake (a, b, cin, sub)
//   out_valid/out_ready: result handshake (sum, cout, overflow)
interface serial_chunk_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
//   x, y : CHUNK-bit addends
//   ci   : carry into bit 0
//   s    : CHUNK-bit sum
//   co   : carry out of bit CHUNK-1
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK:0] c;

    assign c[0] = ci;
    assign co   = c[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   x, y, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH-bit operands are
// summed CHUNK bits per clock, least-significant chunk first, through one
// shared CHUNK-bit ripple stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_chunk_adder_if
//              (operands in, sum/cout/overflow out, valid/ready both sides)
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_chunk_adder_if.slave bus
);
    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t state_q, state_d;

    // Operands shift right one chunk per BUSY edge; their original sign bits
    // are kept aside because the shifted copies lose them.
    logic [WIDTH-1:0] a_q, b_q;
    logic             a_msb_q, b_msb_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] res_q, res_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic [CHUNK-1:0] s;
    logic             co;
    logic             last;

    assign last = (idx_q == LAST);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (a_q[CHUNK-1:0]),
        .y  (b_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );

    // New chunk enters at the top so the final shift leaves chunk 0 at the LSBs.
    if (NCHUNK == 1) begin : g_res_single
        assign res_next = s;
    end else begin : g_res_shift
        assign res_next = {s, res_q[WIDTH-1:CHUNK]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            // Subtraction is A + ~B + 1: invert B here, inject the 1 as carry.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            res_q   <= res_next;
            carry_q <= co;
            if (last) begin
                sum_q  <= res_next;
                cout_q <= co;
                ovf_q  <= (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: three 16-bit instances (CHUNK = 4, 16, 1) exercised
// one at a time against an arithmetic reference model.
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_chunk_adder_if #(.WIDTH(16)) if_c4  ();
    serial_chunk_adder_if #(.WIDTH(16)) if_c16 ();
    serial_chunk_adder_if #(.WIDTH(16)) if_c1  ();

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_c4 (
        .clk (clk), .rst (rst), .bus (if_c4)
    );
    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clk (clk), .rst (rst), .bus (if_c16)
    );
    serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clk (clk), .rst (rst), .bus (if_c1)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic [15:0] sum;
        logic        cout;
        logic        overflow;
    } obs_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Expected accept-to-valid latency in edges: WIDTH/CHUNK + 1.
    int lat [3] = '{5, 2, 17};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t get_obs(int k);
        obs_t o;
        case (k)
            0:       o = {if_c4.in_ready, if_c4.out_valid, if_c4.sum, if_c4.cout, if_c4.overflow};
            1:       o = {if_c16.in_ready, if_c16.out_valid, if_c16.sum, if_c16.cout,
                          if_c16.overflow};
            2:       o = {if_c1.in_ready, if_c1.out_valid, if_c1.sum, if_c1.cout, if_c1.overflow};
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic drive_in(int k, logic v, logic [15:0] va, logic [15:0] vb, logic c, logic s);
        case (k)
            0: begin if_c4.in_valid = v; if_c4.a = va; if_c4.b = vb; if_c4.cin = c; if_c4.sub = s; end
            1: begin
                if_c16.in_valid = v; if_c16.a = va; if_c16.b = vb; if_c16.cin = c; if_c16.sub = s;
            end
            2: begin if_c1.in_valid = v; if_c1.a = va; if_c1.b = vb; if_c1.cin = c; if_c1.sub = s; end
            default: ;
        endcase
    endtask

    task automatic drive_or(int k, logic r);
        case (k)
            0:       if_c4.out_ready = r;
            1:       if_c16.out_ready = r;
            2:       if_c1.out_ready = r;
            default: ;
        endcase
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(logic [15:0] va, logic [15:0] vb, logic c, logic s);
        res_t r;
        int ua = int'(va);
        int ub = int'(vb);
        int sa = int'($signed(va));
        int sb = int'($signed(vb));
        int sres;
        if (s) begin
            r.sum  = 16'(ua - ub);
            r.cout = (ua >= ub);
            sres   = sa - sb;
        end else begin
            r.sum  = 16'(ua + ub + int'(c));
            r.cout = (ua + ub + int'(c)) > 65535;
            sres   = sa + sb + int'(c);
        end
        r.ovf = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic wait_done(int k, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            edges++;
            if (get_obs(k).out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_result(string tag, int k, logic [15:0] va, logic [15:0] vb,
                                logic c, logic s);
        res_t e = model(va, vb, c, s);
        obs_t o = get_obs(k);
        check({tag, " sum"}, 32'(o.sum), 32'(e.sum));
        check({tag, " cout"}, 32'(o.cout), 32'(e.cout));
        check({tag, " ovf"}, 32'(o.overflow), 32'(e.ovf));
    endtask

    // Full transaction from IDLE; optionally retires the result afterwards.
    task automatic do_op(string tag, int k, logic [15:0] va, logic [15:0] vb,
                         logic c, logic s, bit release_res);
        int  edges;
        bit  ok;
        drive_in(k, 1'b1, va, vb, c, s);
        tick();
        check({tag, " accepted"}, 32'(get_obs(k).in_ready), 32'd0);
        drive_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
        wait_done(k, edges, ok);
        check({tag, " timeout"}, 32'(ok), 32'd1);
        check({tag, " latency"}, 32'(edges + 1), 32'(lat[k]));
        check_result(tag, k, va, vb, c, s);
        if (release_res) begin
            drive_or(k, 1'b1);
            tick();
            drive_or(k, 1'b0);
            check({tag, " drop valid"}, 32'(get_obs(k).out_valid), 32'd0);
            check({tag, " idle ready"}, 32'(get_obs(k).in_ready), 32'd1);
        end
    endtask

    logic [15:0] dir_a   [6] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
    logic [15:0] dir_b   [6] = '{16'h1111, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
    logic        dir_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        dir_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        obs_t o0;
        obs_t o;
        int   edges;
        bit   ok;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
            drive_or(k, 1'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = get_obs(k);
            check($sformatf("k%0d reset in_ready", k), 32'(o.in_ready), 32'd1);
            check($sformatf("k%0d reset out_valid", k), 32'(o.out_valid), 32'd0);
            check($sformatf("k%0d reset sum", k), 32'(o.sum), 32'd0);
            check($sformatf("k%0d reset cout", k), 32'(o.cout), 32'd0);
            check($sformatf("k%0d reset ovf", k), 32'(o.overflow), 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            // Directed vectors: plain add, full carry ripple, cin, subtract, overflow.
            for (int i = 0; i < 6; i++) begin
                do_op($sformatf("k%0d dir%0d", k, i), k, dir_a[i], dir_b[i], dir_cin[i],
                      dir_sub[i], 1'b1);
            end

            // Backpressure: result held while new operands wait at the input.
            do_op($sformatf("k%0d bp first", k), k, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
            o0 = get_obs(k);
            drive_in(k, 1'b1, 16'h0F0F, 16'h0101, 1'b1, 1'b0);
            for (int i = 0; i < 5; i++) begin
                tick();
                o = get_obs(k);
                check($sformatf("k%0d bp hold%0d", k, i), 32'(o), 32'(o0));
                check($sformatf("k%0d bp ready%0d", k, i), 32'(o.in_ready), 32'd0);
            end
            drive_or(k, 1'b1);
            tick();
            drive_or(k, 1'b0);
            check($sformatf("k%0d bp idle ready", k), 32'(get_obs(k).in_ready), 32'd1);
            check($sformatf("k%0d bp idle valid", k), 32'(get_obs(k).out_valid), 32'd0);
            tick();
            check($sformatf("k%0d bp pending taken", k), 32'(get_obs(k).in_ready), 32'd0);
            drive_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
            wait_done(k, edges, ok);
            check($sformatf("k%0d bp timeout", k), 32'(ok), 32'd1);
            check_result($sformatf("k%0d bp pending", k), k, 16'h0F0F, 16'h0101, 1'b1, 1'b0);
            drive_or(k, 1'b1);
            tick();
            drive_or(k, 1'b0);

            // Reset at the second BUSY edge discards the operation.
            drive_in(k, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
            tick();
            drive_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            o = get_obs(k);
            check($sformatf("k%0d rst out_valid", k), 32'(o.out_valid), 32'd0);
            check($sformatf("k%0d rst in_ready", k), 32'(o.in_ready), 32'd1);
            check($sformatf("k%0d rst sum", k), 32'(o.sum), 32'd0);
            check($sformatf("k%0d rst cout", k), 32'(o.cout), 32'd0);
            check($sformatf("k%0d rst ovf", k), 32'(o.overflow), 32'd0);

            // No handshake at an edge where rst is high.
            drive_in(k, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            drive_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
            check($sformatf("k%0d rst no accept", k), 32'(get_obs(k).in_ready), 32'd1);

            do_op($sformatf("k%0d post rst", k), k, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
            check($sformatf("k%0d post rst 0100", k), 32'(get_obs(k).sum), 32'h0100);
            drive_or(k, 1'b1);
            tick();
            drive_or(k, 1'b0);

            // Random operands through the model.
            for (int i = 0; i < 8; i++) begin
                do_op($sformatf("k%0d rnd%0d", k, i), k, 16'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle, parametrised two's-complement adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, through a single CHUNK-bit ripple stage. The block sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides. It trades latency for area. It is the sequential, wide-operand successor to the single-bit full adder cell, and it adds subtraction and signed-overflow detection.

## Interface
- WIDTH, 32: operand and result width in bits. Must be ≥ 1.
- CHUNK, 8: bits added per cycle. Must be ≥ 1 and must divide WIDTH.
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0 selects A+B+cin; 1 selects A−B.
- out_valid  out  1  result valid. High only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH−1. For subtraction, 1 means no borrow.
- overflow  out  1  signed two's-complement overflow.

## Operation
- NCHUNK = WIDTH/CHUNK. The chunk counter width is max(1, $clog2(NCHUNK)).
- FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - in_ready=1.
  - When in_valid is high at an edge, the block latches a and b'. b' = sub ? ~b : b.
  - At the same edge it sets carry register = sub ? 1 : cin, sets chunk index = 0, and moves to BUSY.
- **BUSY**
  - in_ready=0.
  - Each edge adds chunk[idx] of A, chunk[idx] of b', and the carry register.
  - The CHUNK-bit result is written into the result shift register and the carry register is updated.
  - At the edge where idx = NCHUNK−1, the block loads sum, cout and overflow and moves to DONE. Otherwise idx increments.
- **DONE**
  - out_valid=1.
  - sum, cout and overflow are held stable.
  - in_valid is ignored.
  - When out_ready is high at an edge, the block moves to IDLE. out_valid drops in the next cycle.
- overflow = (A[WIDTH−1] == b'[WIDTH−1]) && (sum[WIDTH−1] != A[WIDTH−1]).
- sum, cout and overflow change only on the final BUSY edge and on reset. They are not valid in IDLE or BUSY.
- **Reset** (rst high at an edge, in any state, including mid-BUSY):
  - State goes to IDLE, and any in-flight operation is discarded.
  - sum=0, cout=0, overflow=0, out_valid=0, carry register and index are cleared.
  - in_ready=1 from the cycle after reset. No handshake is accepted at an edge where rst is high.
- CHUNK=WIDTH is legal: BUSY lasts exactly one cycle.
- CHUNK=1 is legal: the block is bit-serial.

## Timing
- Operands are accepted at edge E0.
- BUSY spans edges E1…E_NCHUNK.
- out_valid is high in the cycle after edge E_NCHUNK.
- Accept-to-valid latency is NCHUNK+1 edges, counted from the accepting edge to the first edge at which out_valid is sampled high.
- Back-to-back throughput is one operation per NCHUNK+2 cycles when out_ready is held high. There is no overlap between operations.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Reset values: in_ready=1 once rst is low, out_valid=0, sum=0, cout=0, overflow=0.

## Structure
- Package adder_pkg holds:
  - state enum state_t {IDLE, BUSY, DONE};
  - helper function nchunk(WIDTH, CHUNK).
- Sub-module chunk_adder, parametrised by CHUNK, is combinational: (x, y, ci) → (s, co). It is built from a chain of CHUNK full_adder cells.
- Top level contains the FSM, operand registers, index counter, carry register, result shift register and output registers.
- An elaboration-time assertion rejects WIDTH % CHUNK != 0.

## Test plan
All scenarios use WIDTH=16 and CHUNK=4 unless stated.
- Add, no carry: a=0x1234, b=0x1111, cin=0, sub=0 → sum=0x2345, cout=0, overflow=0. out_valid is sampled high exactly 5 edges after the accepting edge.
- Carry across all chunks: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Also a=0x0000, b=0x0000, cin=1 → sum=0x0001.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (cin must be ignored) → sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
- Signed add overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Outputs stay stable, in_ready=0, and the new operands are not taken.
  - After out_ready=1, the block returns to IDLE and accepts the pending operands.
- Reset mid-BUSY: assert rst at the second BUSY edge.
  - Next cycle: out_valid=0, in_ready=1, sum=0.
  - A following 0x00FF+0x0001 completes with sum=0x0100.
  - Repeat the suite with CHUNK=16 (latency 2 edges) and with CHUNK=1.
